// File: rtl/cpu_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline has priority, then load return and the
// divider share the port round-robin. Also holds the pending-write scoreboard for p2 stalls.
module cpu_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  p4_dest_reg,
  input  logic [31:0] p4_result,
  input  logic        mem_valid,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        div_valid,
  input  logic [4:0]  div_dest,
  input  logic [31:0] div_data,
  output logic        div_ready,
  input  logic [4:0]  p2_reg_a,
  input  logic [4:0]  p2_reg_b,
  input  logic        p2_literal_b,
  input  logic        p2_sb_set,
  input  logic [4:0]  p2_sb_reg,
  output logic        p2_stall,
  output logic        p2_hold,
  output logic [4:0]  p5_dest_reg,
  output logic [31:0] p5_result
);

  typedef enum logic {
    RR_MEM = 1'b0,
    RR_DIV = 1'b1
  } rr_e;

  localparam logic [3:0] HOLD_AT  = 4'(STARVE_LIMIT - 1);
  localparam logic [3:0] CNT_MAX  = 4'd15;

  rr_e         rr_ptr;
  logic [31:0] pending;
  logic [3:0]  starve_cnt;

  logic        pipe_wr;
  logic        mem_pick;
  logic        div_pick;
  logic        slow_gnt;
  logic        starving;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    pipe_wr   = 1'b0;
    mem_pick  = 1'b0;
    div_pick  = 1'b0;
    mem_ready = 1'b0;
    div_ready = 1'b0;
    slow_gnt  = 1'b0;
    starving  = 1'b0;
    p2_stall  = 1'b0;
    set_vec   = '0;
    clr_vec   = '0;

    pipe_wr   = (p4_dest_reg != 5'd0);
    mem_pick  = mem_valid && (!div_valid || rr_ptr == RR_MEM);
    div_pick  = div_valid && !mem_pick;
    mem_ready = reset_n && !pipe_wr && mem_pick;
    div_ready = reset_n && !pipe_wr && div_pick;
    slow_gnt  = mem_ready || div_ready;
    starving  = (mem_valid || div_valid) && !slow_gnt;

    // Stall looks only at registered pending state; a same-cycle clear releases next cycle.
    p2_stall  = pending[p2_reg_a]
              | (!p2_literal_b && pending[p2_reg_b])
              | (p2_sb_set && pending[p2_sb_reg]);

    if (p2_sb_set && !p2_stall && p2_sb_reg != 5'd0)
      set_vec = 32'd1 << p2_sb_reg;
    if (mem_ready)
      clr_vec = 32'd1 << mem_dest;
    else if (div_ready)
      clr_vec = 32'd1 << div_dest;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p5_dest_reg <= '0;
      p5_result   <= '0;
      rr_ptr      <= RR_MEM;
      // NOTE: the scoreboard is reset explicitly; stale pending bits would stall p2 forever.
      pending     <= '0;
      starve_cnt  <= '0;
      p2_hold     <= 1'b0;
    end else begin
      if (pipe_wr) begin
        p5_dest_reg <= p4_dest_reg;
        p5_result   <= p4_result;
      end else if (mem_ready) begin
        p5_dest_reg <= mem_dest;
        p5_result   <= mem_data;
      end else if (div_ready) begin
        p5_dest_reg <= div_dest;
        p5_result   <= div_data;
      end else begin
        p5_dest_reg <= '0;
      end

      if (mem_ready)
        rr_ptr <= RR_DIV;
      else if (div_ready)
        rr_ptr <= RR_MEM;

      // Set and clear never hit the same register in one cycle; bit 0 is never pending.
      pending <= ((pending & ~clr_vec) | set_vec) & ~32'd1;

      p2_hold <= 1'b0;
      if (starving) begin
        if (starve_cnt == HOLD_AT) begin
          p2_hold    <= 1'b1;
          starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // A pipeline write to a register still awaiting a slow result is a protocol error.
  pipe_write_to_pending : assert property (
    @(posedge clock) disable iff (!reset_n) pipe_wr |-> !pending[p4_dest_reg]
  );

endmodule

// File: doc/cpu_wb_arbiter.md
Name: cpu_wb_arbiter

Overview:
- Owns the single register-file write port (p5_dest_reg / p5_result) and shares it between three writers: the main pipeline, load-data return from memory, and the multi-cycle divider.
- Keeps a 32-entry pending-write scoreboard for long-latency destinations.
- Stalls p2 when an operand or destination is still in flight.
- Forces a pipeline bubble when a slow writer has been starved too long.

Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles for a valid slow writer before p2_hold is raised (range 1..15).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- p4_dest_reg  input  5  pipeline writeback register; 0 = no write
- p4_result  input  32  pipeline writeback data
- mem_valid  input  1  load data available
- mem_dest  input  5  load destination register
- mem_data  input  32  load data
- mem_ready  output  1  load write granted this cycle (combinational)
- div_valid  input  1  divider result available
- div_dest  input  5  divider destination register
- div_data  input  32  divider result
- div_ready  output  1  divider write granted this cycle (combinational)
- p2_reg_a  input  5  p2 source A
- p2_reg_b  input  5  p2 source B
- p2_literal_b  input  1  operand B is a literal; reg_b is not checked
- p2_sb_set  input  1  p2 instruction is a long-latency op (load/divide)
- p2_sb_reg  input  5  its destination register
- p2_stall  output  1  hold p2 this cycle (combinational)
- p2_hold  output  1  registered request to inject one bubble (pipeline drives p4_dest_reg=0)
- p5_dest_reg  output  5  register-file write address; 0 = no write
- p5_result  output  32  register-file write data

Behaviour:
- Reset (async, reset_n low): p5_dest_reg=0, p5_result=0, all pending bits=0, rr_ptr=MEM, starve counter=0, p2_hold=0. mem_ready/div_ready are 0 while in reset.
- Priority:
  - The pipeline wins whenever p4_dest_reg!=0 and is never stalled by this block.
  - Otherwise the port is granted to one valid slow writer, round-robin. rr_ptr names the preferred writer.
  - After a grant, rr_ptr moves to the other writer.
  - If only one slow writer is valid, it wins and rr_ptr still flips.
- Handshake:
  - mem_ready / div_ready = grant. A transfer happens when valid && ready.
  - Writers hold valid/dest/data stable until ready.
  - A slow writer with dest=0 is granted normally, consumed, and produces no write.
- Latency: the granted writer's dest/data appear on p5_dest_reg/p5_result on the next rising edge (1 cycle). With no writer, p5_dest_reg=0 and p5_result holds its last value.
- Scoreboard:
  - pending[r] is set on the edge when p2_sb_set && !p2_stall && p2_sb_reg!=0.
  - pending[r] is cleared on the edge when a slow-writer transfer to r occurs.
  - pending[0] is always 0.
- p2_stall = (pending[p2_reg_a]) | (!p2_literal_b && pending[p2_reg_b]) | (p2_sb_set && pending[p2_sb_reg]).
  - The last term blocks WAW.
  - Stalling uses pending state only; a clear in the same cycle releases the stall on the following cycle.
  - Because a set requires !p2_stall, set and clear of the same register never coincide.
- Pipeline write to a pending register is a protocol error: the write proceeds and the pending bit is unchanged. A simulation-only assertion flags it.
- Starvation:
  - The counter increments on each cycle where any slow writer is valid and none is granted. It resets to 0 on any slow grant or when no slow writer is valid. It saturates at 15.
  - When counter == STARVE_LIMIT-1 and the condition still holds, p2_hold is registered high for exactly one cycle and the counter returns to 0.
  - Within one cycle after p2_hold, the pipeline presents p4_dest_reg=0 and a slow grant follows.
- Reset mid-transfer: all pending state is lost. Writers must also be reset by the same reset_n.

Test Plan:
- Reset, then mem_valid=1, mem_dest=7, mem_data=0xDEADBEEF with pipeline idle -> mem_ready=1 the same cycle; next cycle p5_dest_reg=7, p5_result=0xDEADBEEF.
- p4_dest_reg=3, p4_result=0x11 together with mem_valid and div_valid -> both readys=0; p5=3/0x11. Next cycle with the pipeline idle, mem is granted; the cycle after, div is granted (round-robin).
- p2_sb_set=1, p2_sb_reg=5, then p2_reg_a=5 -> p2_stall=1 until div completes to r5; p2_stall=0 the cycle after the div transfer.
- p2_reg_b=5 pending with p2_literal_b=1 -> p2_stall=0. With p2_literal_b=0 -> p2_stall=1. p2_sb_set with p2_sb_reg=5 while pending -> stall and no new set.
- STARVE_LIMIT=4, mem_valid held, p4_dest_reg nonzero every cycle -> p2_hold pulses high for one cycle after 4 denied cycles. The bench drops p4_dest_reg to 0, mem is granted, and the counter returns to 0.
- Assert reset_n=0 with pending[9]=1 and mem_valid held -> p5_dest_reg=0, mem_ready=0, pending cleared immediately (asynchronously). After release, reading r9 gives p2_stall=0.
